// File: rtl/duty_setpoint_ctrl.sv
// Multi-channel PWM duty setpoint bank: saturating inc/dec steps from button levels,
// press-and-hold auto-repeat, direct clamped load, and status flags for the selected channel.
//
// state  | meaning
// IDLE   | waiting for a fresh press on inc_in or dec_in
// HOLD   | button held after the first step; counting to the first auto-repeat
// REPEAT | auto-repeating every REPEAT_CYCLES while the button stays held
module duty_setpoint_ctrl #(
    parameter int NUM_CH        = 2,
    parameter int WIDTH         = 17,
    parameter int PERIOD        = 100000,
    parameter int STEP          = 2000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int RESET_VAL     = 0,
    localparam int CHW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    inc_in,
    input  logic                    dec_in,
    input  logic [CHW-1:0]          ch_sel,
    input  logic                    load_en,
    input  logic [WIDTH-1:0]        load_val,
    output logic [NUM_CH*WIDTH-1:0] duty_flat,
    output logic [WIDTH-1:0]        sel_duty,
    output logic                    at_max,
    output logic                    at_min,
    output logic                    step_pulse
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [WIDTH-1:0] PER_W   = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LIM_W   = WIDTH'(PERIOD - STEP);
    localparam logic [TW-1:0]    HOLD_T  = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0]    REP_T   = TW'(REPEAT_CYCLES);

    logic [WIDTH-1:0] duty [NUM_CH];
    logic [1:0]       state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic             inc_q, dec_q;
    logic             dir_inc, dir_nx;
    logic [CHW-1:0]   ch_q;

    logic [WIDTH-1:0] cur, inc_val, dec_val, load_clamped, step_val, wr_val;
    logic             inc_press, dec_press, active_lvl, other_lvl, abort, wr_en;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_flat
            assign duty_flat[g*WIDTH +: WIDTH] = duty[g];
        end
    endgenerate

    assign cur          = duty[ch_sel];
    assign sel_duty     = cur;
    assign at_max       = (cur == PER_W);
    assign at_min       = (cur == '0);

    assign inc_val      = (cur > LIM_W) ? PER_W : cur + STEP_W;
    assign dec_val      = (cur < STEP_W) ? '0 : cur - STEP_W;
    assign step_val     = dir_inc ? inc_val : dec_val;
    assign load_clamped = (load_val > PER_W) ? PER_W : load_val;

    assign inc_press    = inc_in & ~inc_q & ~dec_in;
    assign dec_press    = dec_in & ~dec_q & ~inc_in;
    assign active_lvl   = dir_inc ? inc_in : dec_in;
    assign other_lvl    = dir_inc ? dec_in : inc_in;
    // Entering HOLD requires the other button low, so "other high" means it rose.
    assign abort        = ~active_lvl | other_lvl | (ch_sel != ch_q);

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        dir_nx   = dir_inc;
        wr_en    = 1'b0;
        wr_val   = cur;
        if (load_en) begin
            wr_en    = 1'b1;
            wr_val   = load_clamped;
            state_nx = IDLE;
            timer_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inc_press) begin
                        wr_en    = 1'b1;
                        wr_val   = inc_val;
                        dir_nx   = 1'b1;
                        state_nx = HOLD;
                        timer_nx = TW'(1);
                    end else if (dec_press) begin
                        wr_en    = 1'b1;
                        wr_val   = dec_val;
                        dir_nx   = 1'b0;
                        state_nx = HOLD;
                        timer_nx = TW'(1);
                    end
                end
                HOLD, REPEAT: begin
                    if (abort) begin
                        state_nx = IDLE;
                        timer_nx = '0;
                    end else if (timer == ((state == HOLD) ? HOLD_T : REP_T)) begin
                        wr_en    = 1'b1;
                        wr_val   = step_val;
                        state_nx = REPEAT;
                        timer_nx = TW'(1);
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) duty[i] <= WIDTH'(RESET_VAL);
            state      <= IDLE;
            timer      <= '0;
            inc_q      <= 1'b1;
            dec_q      <= 1'b1;
            dir_inc    <= 1'b1;
            ch_q       <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            inc_q      <= inc_in;
            dec_q      <= dec_in;
            dir_inc    <= dir_nx;
            ch_q       <= ch_sel;
            step_pulse <= wr_en && (wr_val != cur);
            if (wr_en) duty[ch_sel] <= wr_val;
        end
    end

endmodule

// File: tb/tb_duty_setpoint_ctrl.sv
// Directed bench for duty_setpoint_ctrl with small parameters so hold/repeat timing
// and saturation can be checked edge by edge.
module tb_duty_setpoint_ctrl;

    localparam int W = 5;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           inc_in, dec_in, load_en;
    logic [0:0]     ch_sel;
    logic [W-1:0]   load_val;
    logic [2*W-1:0] duty_flat;
    logic [W-1:0]   sel_duty;
    logic           at_max, at_min, step_pulse;

    int errors = 0;
    int checks = 0;

    duty_setpoint_ctrl #(
        .NUM_CH(2), .WIDTH(W), .PERIOD(10), .STEP(3),
        .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .RESET_VAL(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .inc_in(inc_in), .dec_in(dec_in),
        .ch_sel(ch_sel), .load_en(load_en), .load_val(load_val),
        .duty_flat(duty_flat), .sel_duty(sel_duty), .at_max(at_max),
        .at_min(at_min), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ch(input int i);
        return 32'(duty_flat[i*W +: W]);
    endfunction

    task automatic do_load(input logic [0:0] c, input logic [W-1:0] v);
        ch_sel   = c;
        load_val = v;
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
    endtask

    int exp_v[5] = '{3, 6, 9, 10, 10};
    int exp_p[5] = '{1, 1, 1, 1, 0};
    int e;

    initial begin
        reset_n = 1'b0; inc_in = 1'b1; dec_in = 1'b0; ch_sel = 1'b0;
        load_en = 1'b0; load_val = '0;
        #23;
        chk("rst_ch0", ch(0), 0);
        chk("rst_ch1", ch(1), 0);
        chk("rst_pulse", 32'(step_pulse), 0);
        chk("rst_at_min", 32'(at_min), 1);
        chk("rst_at_max", 32'(at_max), 0);

        // 1: inc held through reset release must not step
        @(negedge clk); reset_n = 1'b1;
        repeat (3) tick();
        chk("held_rst_ch0", ch(0), 0);
        chk("held_rst_at_min", 32'(at_min), 1);
        inc_in = 1'b0; tick();
        inc_in = 1'b1; tick();
        chk("repress_ch0", ch(0), 3);
        chk("repress_pulse", 32'(step_pulse), 1);
        inc_in = 1'b0; tick();
        chk("pulse_clear", 32'(step_pulse), 0);

        // 2: single presses up to saturation
        do_load(1'b0, 5'd0);
        chk("load0_ch0", ch(0), 0);
        for (int i = 0; i < 5; i++) begin
            inc_in = 1'b1; tick();
            chk($sformatf("press%0d_ch0", i), ch(0), 32'(exp_v[i]));
            chk($sformatf("press%0d_pulse", i), 32'(step_pulse), 32'(exp_p[i]));
            inc_in = 1'b0; tick();
        end
        chk("sat_at_max", 32'(at_max), 1);
        chk("sat_sel_duty", 32'(sel_duty), 10);
        chk("sat_ch1", ch(1), 0);

        // 3: hold on ch1, auto-repeat at edges 8, 12, 16
        ch_sel = 1'b1; inc_in = 1'b1; tick();
        chk("hold_e0", ch(1), 3);
        for (int k = 1; k <= 20; k++) begin
            tick();
            e = (k < 8) ? 3 : (k < 12) ? 6 : (k < 16) ? 9 : 10;
            chk($sformatf("hold_e%0d", k), ch(1), 32'(e));
            chk($sformatf("hold_pulse_e%0d", k), 32'(step_pulse),
                (k == 8 || k == 12 || k == 16) ? 1 : 0);
        end
        chk("hold_at_max", 32'(at_max), 1);
        chk("hold_ch0", ch(0), 10);
        inc_in = 1'b0; tick();

        // 5: clamped load and load aborting a hold
        do_load(1'b1, 5'd4);
        chk("load4_ch1", ch(1), 4);
        do_load(1'b1, 5'd25);
        chk("load25_ch1", ch(1), 10);
        chk("load25_pulse", 32'(step_pulse), 1);
        do_load(1'b1, 5'd0);
        inc_in = 1'b1; tick();
        chk("lhold_e0", ch(1), 3);
        repeat (5) tick();
        load_val = 5'd1; load_en = 1'b1; tick(); load_en = 1'b0;
        chk("lhold_load", ch(1), 1);
        repeat (20) tick();
        chk("lhold_no_repeat", ch(1), 1);
        chk("lhold_pulse", 32'(step_pulse), 0);
        inc_in = 1'b0; tick();

        // 4: dec saturation, both buttons high
        do_load(1'b0, 5'd2);
        chk("load2_ch0", ch(0), 2);
        dec_in = 1'b1; tick();
        chk("dec_ch0", ch(0), 0);
        chk("dec_at_min", 32'(at_min), 1);
        chk("dec_pulse", 32'(step_pulse), 1);
        dec_in = 1'b0; tick();
        do_load(1'b0, 5'd5);
        inc_in = 1'b1; dec_in = 1'b1; tick();
        chk("both_ch0", ch(0), 5);
        chk("both_pulse", 32'(step_pulse), 0);
        repeat (3) tick();
        chk("both_hold_ch0", ch(0), 5);
        dec_in = 1'b0;
        repeat (3) tick();
        chk("both_drop_dec_ch0", ch(0), 5);
        inc_in = 1'b0; tick();

        // channel change mid-hold aborts without touching either channel
        inc_in = 1'b1; tick();
        chk("chg_e0", ch(0), 8);
        repeat (2) tick();
        ch_sel = 1'b1; tick();
        repeat (15) tick();
        chk("chg_ch0", ch(0), 8);
        chk("chg_ch1", ch(1), 1);
        inc_in = 1'b0; tick();

        // 6: reset mid-REPEAT
        do_load(1'b0, 5'd0);
        inc_in = 1'b1; tick();
        chk("r6_e0", ch(0), 3);
        repeat (8) tick();
        chk("r6_e8", ch(0), 6);
        repeat (2) tick();
        reset_n = 1'b0; #1;
        chk("r6_async_ch0", ch(0), 0);
        chk("r6_async_ch1", ch(1), 0);
        chk("r6_async_pulse", 32'(step_pulse), 0);
        repeat (2) tick();
        @(negedge clk); reset_n = 1'b1;
        repeat (12) tick();
        chk("r6_held_ch0", ch(0), 0);
        inc_in = 1'b0; tick();
        inc_in = 1'b1; tick();
        chk("r6_repress_ch0", ch(0), 3);
        inc_in = 1'b0; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
